dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the single-cycle datapath's load/store port: the datapath issues data address, write data and write strobe; this block serves them.
- Holds a word-addressed data RAM with a configurable access latency and a valid/ready request plus one-shot response handshake.
- Drives a stall back to the core so the PC and register write-back freeze until the load or store completes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..65536.
- LATENCY, 2, wait cycles between accept and response; 0..15.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- req_valid_i  in  1  core presents a memory request.
- req_write_i  in  1  1 = store, 0 = load; sampled with the request.
- req_addr_i32  in  32  byte address (ALU result).
- req_wdata_i32  in  32  store data.
- req_ready_o  out  1  block can accept a request this cycle.
- resp_valid_o  out  1  one-cycle pulse: access complete.
- resp_rdata_o32  out  32  load data; valid only with resp_valid_o.
- err_o  out  1  pulses with resp_valid_o on a bad address.
- stall_o  out  1  core must hold PC and suppress register write.

Behaviour:
- Clock and reset: single clock clk_i. reset_i is synchronous and active-low.
- Reset values, while reset_i=0: state IDLE, req_ready_o=0, resp_valid_o=0, resp_rdata_o32=0, err_o=0, stall_o=0, counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i=1:
  - capture addr, write and wdata into holding registers;
  - go to WAIT with counter=LATENCY-1 if LATENCY>0, else go to RESP.
- WAIT: req_ready_o=0. Counter decrements each cycle. When the counter is 0, the RAM access occurs on that edge (write commits, read data registers) and the FSM moves to RESP.
- LATENCY=0 case: the access occurs on the accepting edge.
- RESP: resp_valid_o=1 for exactly one cycle, req_ready_o=0, then return to IDLE.
- Latency: request accepted in cycle T gives resp_valid_o in cycle T+1+LATENCY. The earliest next accept is the cycle after RESP.
- stall_o is combinational: (IDLE & req_valid_i) | WAIT. It is 0 in RESP so the core advances that cycle using resp_rdata_o32.
- Address rules:
  - Word index = addr[2+log2(DEPTH_WORDS)-1:2].
  - Error if addr[1:0]!=0 or addr[31:2] >= DEPTH_WORDS.
  - On error: no RAM write, resp_rdata_o32=0, err_o=1 with the response. Timing is identical to a good access.
- resp_rdata_o32 holds its last value outside RESP. For stores it returns the pre-write word (read-before-write).
- Input changes on req_* after accept are ignored; only the holding registers are used.
- Reset mid-operation: returns to IDLE next edge. A pending store that has not yet reached its commit edge is dropped. No response is issued.
- req_valid_i while not ready is ignored. The core must hold the request; that is its obligation, not checked here.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- Defined:
  - adds port req_be_i4 (in, 4), captured at accept;
  - a store updates only byte lanes with be=1 (lane 0 = bits 7:0);
  - be=4'b0000 store is a legal no-op with a normal response;
  - loads ignore be.
- Not defined: port absent; every store writes the full word.

Decomposition:
- Package dmem_pkg:
  - state enum dmem_state_e {IDLE, WAIT, RESP};
  - LAT_W=4 latency counter width constant;
  - function addr_ok(addr, depth).
- Sub-module dmem_array:
  - synchronous-write, registered-read RAM, DEPTH_WORDS x 32;
  - write-enable plus optional 4-bit lane mask;
  - read-before-write on same-address access.
- FSM, counter and error logic stay in dmem_responder.

Test Plan:
- LATENCY=2, store addr 0x10 data 0xDEADBEEF accepted cycle 0 -> stall_o=1 cycles 0-2, resp_valid_o=1 cycle 3 only, err_o=0, req_ready_o=0 cycles 1-3. Load 0x10 afterwards -> resp_rdata_o32=0xDEADBEEF three cycles after accept.
- LATENCY=0, load 0x10 accepted cycle 0 -> resp_valid_o cycle 1 with 0xDEADBEEF; stall_o=1 only in cycle 0.
- Load 0x13 -> err_o=1 with resp_rdata_o32=0. Store 0x400 at DEPTH_WORDS=256 -> err_o=1, and a later load 0x0 is unchanged.
- Word 0x20 holds 0x00001111. Store 0x20 data 0x00001234, reset_i=0 for one cycle in WAIT (LATENCY=4) -> no resp_valid_o; later load 0x20 returns 0x00001111.
- Back-to-back: req_valid_i held high with two requests -> second accepted the cycle after the first resp_valid_o; no overlap of responses.
- DMEM_BYTE_STROBE_EN, word = 0xDEADBEEF: store 0xAABBCCDD with be=4'b0010 -> load returns 0xDEADCCEF. be=4'b0000 -> word unchanged, resp_valid_o still pulses.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, counter width and address check for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

    localparam int LAT_W = 4;

    function automatic logic addr_ok(input logic [31:0] addr, input int depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < $unsigned(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with lane-masked synchronous write and registered read-before-write
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Commit only the enabled byte lanes of a store
    always_ff @(posedge clk_i) begin
        if (en && we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    // Capture the word as it was before this edge's write; cleared by reset
    always_ff @(posedge clk_i) begin
        if (!reset_i) rdata <= '0;
        else if (en)  rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: latency-configurable data RAM behind a valid/ready request and one-shot response.
// Define DMEM_BYTE_STROBE_EN to add the req_be_i4 byte-lane store mask.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i32,
    input  logic [31:0] req_wdata_i32,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  req_be_i4,
`endif
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o32,
    output logic        err_o,
    output logic        stall_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY > 0 ? LATENCY - 1 : 0);

    dmem_state_e      state, state_nx;
    logic [LAT_W-1:0] cnt, cnt_nx;
    logic [31:0]      h_addr, h_wdata, acc_addr, acc_wdata, arr_rdata;
    logic             h_write, acc_write, access, ok, err_q;
    logic [3:0]       acc_be;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]       h_be;
`endif

    // With zero latency the access uses the live request; otherwise the held copy
    assign acc_addr  = (state == IDLE) ? req_addr_i32  : h_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata_i32 : h_wdata;
    assign acc_write = (state == IDLE) ? req_write_i   : h_write;
`ifdef DMEM_BYTE_STROBE_EN
    assign acc_be    = (state == IDLE) ? req_be_i4     : h_be;
`else
    assign acc_be    = 4'hF;
`endif
    assign ok = addr_ok(acc_addr, DEPTH_WORDS);

    // Next state, wait counter and the edge on which the RAM is touched
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        case (state)
            IDLE: if (req_valid_i) begin
                state_nx = (LATENCY == 0) ? RESP : WAIT;
                cnt_nx   = CNT_INIT;
                access   = (LATENCY == 0);
            end
            WAIT: begin
                cnt_nx   = (cnt == '0) ? '0 : cnt - LAT_W'(1);
                state_nx = (cnt == '0) ? RESP : WAIT;
                access   = (cnt == '0);
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, counter and the error flag that travels with the response
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (access) err_q <= !ok;
        end
    end

    // Hold the accepted request so later changes on the request bus are ignored
    always_ff @(posedge clk_i) begin
        if (state == IDLE && req_valid_i) begin
            h_addr  <= req_addr_i32;
            h_wdata <= req_wdata_i32;
            h_write <= req_write_i;
`ifdef DMEM_BYTE_STROBE_EN
            h_be    <= req_be_i4;
`endif
        end
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en      (access && ok && reset_i),
        .we      (acc_write),
        .be      (acc_be),
        .addr    (acc_addr[AW+1:2]),
        .wdata   (acc_wdata),
        .rdata   (arr_rdata)
    );

    assign req_ready_o    = reset_i && (state == IDLE);
    assign resp_valid_o   = reset_i && (state == RESP);
    assign err_o          = resp_valid_o && err_q;
    assign stall_o        = reset_i && ((state == IDLE && req_valid_i) || state == WAIT);
    assign resp_rdata_o32 = (reset_i && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (latency 2, 0, 4) checked every cycle against a transaction-level model
module tb_dmem_responder;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        rst_n [3];
    logic        vld [3], wr [3];
    logic [31:0] ad [3], wd [3];
    logic [3:0]  be [3];
    logic        rdy [3], rv [3], er [3], st [3];
    logic [31:0] rd [3];

    localparam int LAT [3] = '{2, 0, 4};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.DEPTH_WORDS(256), .LATENCY(g == 0 ? 2 : (g == 1 ? 0 : 4))) u_dut (
            .clk_i          (clk),
            .reset_i        (rst_n[g]),
            .req_valid_i    (vld[g]),
            .req_write_i    (wr[g]),
            .req_addr_i32   (ad[g]),
            .req_wdata_i32  (wd[g]),
`ifdef DMEM_BYTE_STROBE_EN
            .req_be_i4      (be[g]),
`endif
            .req_ready_o    (rdy[g]),
            .resp_valid_o   (rv[g]),
            .resp_rdata_o32 (rd[g]),
            .err_o          (er[g]),
            .stall_o        (st[g])
        );
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Model: a request is outstanding from accept until its response cycle (accept + 1 + latency).
    bit          busy [3];
    int          due [3];
    logic [31:0] ma [3], md [3], mrd [3];
    logic        mw [3], merr [3];
    logic [3:0]  mb [3];
    logic [31:0] mm [3][256];

    always @(negedge clk) begin : cmp
        logic e_rdy, e_rv, e_st, bad;
        for (int k = 0; k < 3; k++) begin
            e_rdy = rst_n[k] && !busy[k];
            e_rv  = rst_n[k] && busy[k] && cyc == due[k];
            e_st  = rst_n[k] && ((!busy[k] && vld[k]) || (busy[k] && cyc < due[k]));
            chk($sformatf("ready[%0d]", k), rdy[k], e_rdy);
            chk($sformatf("resp_valid[%0d]", k), rv[k], e_rv);
            chk($sformatf("stall[%0d]", k), st[k], e_st);
            chk($sformatf("err[%0d]", k), er[k], e_rv && merr[k]);
            if (!$isunknown(mrd[k]))
                chk($sformatf("rdata[%0d]", k), rd[k], rst_n[k] ? mrd[k] : 32'h0);
            if (!rst_n[k]) begin
                busy[k] = 0;
                mrd[k]  = 0;
                merr[k] = 0;
            end else begin
                if (busy[k] && cyc == due[k]) busy[k] = 0;
                else if (!busy[k] && vld[k]) begin
                    busy[k] = 1;
                    due[k]  = cyc + 1 + LAT[k];
                    ma[k]   = ad[k];
                    md[k]   = wd[k];
                    mw[k]   = wr[k];
`ifdef DMEM_BYTE_STROBE_EN
                    mb[k]   = be[k];
`else
                    mb[k]   = 4'hF;
`endif
                end
                if (busy[k] && cyc == due[k] - 1) begin
                    bad     = ma[k][1:0] != 2'b00 || ma[k][31:2] >= 30'd256;
                    merr[k] = bad;
                    mrd[k]  = bad ? 32'h0 : mm[k][ma[k][9:2]];
                    if (mw[k] && !bad)
                        for (int i = 0; i < 4; i++)
                            if (mb[k][i]) mm[k][ma[k][9:2]][8*i +: 8] = md[k][8*i +: 8];
                end
            end
        end
    end

    task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] r, output logic e, output int lat);
        int t0;
        bit got;
        @(posedge clk); #1;
        vld[k] = 1; wr[k] = w; ad[k] = a; wd[k] = d; be[k] = b;
        got = 0; t0 = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rdy[k]) begin got = 1; t0 = cyc; end
        end
        @(posedge clk); #1;
        vld[k] = 0; wr[k] = ~w; ad[k] = '1; wd[k] = $urandom; be[k] = ~b;
        if (!got) chk($sformatf("accept_timeout[%0d]", k), 0, 1);
        got = 0; lat = -1; r = 0; e = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rv[k]) begin got = 1; lat = cyc - t0; r = rd[k]; e = er[k]; end
        end
        if (!got) chk($sformatf("resp_timeout[%0d]", k), 0, 1);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          l, nacc, a1, a2, r1, r2, nresp;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 0; vld[k] = 0; wr[k] = 0; ad[k] = 0; wd[k] = 0; be[k] = 4'hF;
            busy[k] = 0; due[k] = 0; mrd[k] = 0; merr[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1;

        do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, l);
        chk("st_lat", l, 3);
        chk("st_err", e, 0);
        do_req(0, 0, 32'h10, 32'h0, 4'hF, r, e, l);
        chk("ld_lat", l, 3);
        chk("ld_data", r, 32'hDEADBEEF);
        do_req(0, 0, 32'h13, 32'h0, 4'hF, r, e, l);
        chk("mis_err", e, 1);
        chk("mis_data", r, 32'h0);
        chk("mis_lat", l, 3);
        do_req(0, 1, 32'h0, 32'h00000055, 4'hF, r, e, l);
        do_req(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, r, e, l);
        chk("oob_err", e, 1);
        do_req(0, 0, 32'h0, 32'h0, 4'hF, r, e, l);
        chk("oob_keep", r, 32'h00000055);
        do_req(0, 1, 32'h10, 32'h12345678, 4'hF, r, e, l);
        chk("rbw_data", r, 32'hDEADBEEF);

        @(posedge clk); #1;
        vld[0] = 1; wr[0] = 0; ad[0] = 32'h10;
        nacc = 0; nresp = 0; a1 = 0; a2 = 0; r1 = 0; r2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv[0]) begin
                if (nresp == 0) r1 = cyc; else r2 = cyc;
                nresp++;
            end
            if (rdy[0] && vld[0]) begin
                if (nacc == 0) a1 = cyc; else a2 = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            if (nacc == 1) ad[0] = 32'h0;
            if (nacc >= 2) vld[0] = 0;
        end
        chk("b2b_resps", nresp, 2);
        chk("b2b_first", r1 - a1, 3);
        chk("b2b_next_acc", a2 - r1, 1);
        chk("b2b_second", r2 - a2, 3);

`ifdef DMEM_BYTE_STROBE_EN
        do_req(0, 1, 32'h30, 32'hDEADBEEF, 4'hF, r, e, l);
        do_req(0, 1, 32'h30, 32'hAABBCCDD, 4'b0010, r, e, l);
        do_req(0, 0, 32'h30, 32'h0, 4'hF, r, e, l);
        chk("be_lane1", r, 32'hDEADCCEF);
        do_req(0, 1, 32'h30, 32'h11111111, 4'b0000, r, e, l);
        chk("be0_lat", l, 3);
        chk("be0_err", e, 0);
        do_req(0, 0, 32'h30, 32'h0, 4'b0000, r, e, l);
        chk("be0_keep", r, 32'hDEADCCEF);
`endif

        do_req(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, l);
        chk("l0_st_lat", l, 1);
        do_req(1, 0, 32'h10, 32'h0, 4'hF, r, e, l);
        chk("l0_ld_lat", l, 1);
        chk("l0_ld_data", r, 32'hDEADBEEF);

        do_req(2, 1, 32'h20, 32'h00001111, 4'hF, r, e, l);
        chk("l4_st_lat", l, 5);
        @(posedge clk); #1;
        vld[2] = 1; wr[2] = 1; ad[2] = 32'h20; wd[2] = 32'h00001234; be[2] = 4'hF;
        @(negedge clk);
        chk("rst_accept", rdy[2], 1);
        @(posedge clk); #1;
        vld[2] = 0;
        @(posedge clk); #1;
        rst_n[2] = 0;
        @(posedge clk); #1;
        rst_n[2] = 1;
        nresp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rv[2]) nresp++;
        end
        chk("rst_noresp", nresp, 0);
        do_req(2, 0, 32'h20, 32'h0, 4'hF, r, e, l);
        chk("rst_drop", r, 32'h00001111);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
